// File: rtl/updown_dir_conditioner.sv
// Up/down direction pad conditioner.
// Brings the asynchronous direction pad into the clk domain, debounces it,
// and presents a clean registered direction level with one-cycle edge
// pulses. It also keeps a saturating count of rejected level changes for
// debug visibility.
module updown_dir_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pad_in,
  input  logic                glitch_clr,
  output logic                up_down,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                pad_oeb
);

  // The qualification counter only ever holds 1..DEBOUNCE_CYCLES-1 while
  // qualifying, and 0 otherwise.
  localparam int QCNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [QCNT_W-1:0] QCNT_ONE  = QCNT_W'(1);
  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;

  state_t                 state;
  state_t                 state_nxt;
  logic [QCNT_W-1:0]      qcnt;
  logic [QCNT_W-1:0]      qcnt_nxt;
  logic                   up_down_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic                   busy_nxt;
  logic                   glitch_hit;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    logic [GLITCH_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + GLITCH_W'(1);
    end
    return r;
  endfunction

  // The pad is always used as an input.
  assign pad_oeb = 1'b1;

  // Debounce decisions are made on the last synchroniser flop only.
  assign s = sync_p0[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous pad level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad_in};
    end
  end

  // Next-state and output decode for the debounce FSM.
  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    up_down_nxt = up_down;
    rise_nxt    = 1'b0;
    fall_nxt    = 1'b0;
    glitch_hit  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          state_nxt = QUAL_HI;
          qcnt_nxt  = QCNT_ONE;
        end
      end
      QUAL_HI: begin
        if (!s) begin
          // Bounced back before qualifying: drop all accumulated credit.
          state_nxt  = STABLE_LO;
          qcnt_nxt   = '0;
          glitch_hit = 1'b1;
        end else if (qcnt == QCNT_LAST) begin
          state_nxt   = STABLE_HI;
          qcnt_nxt    = '0;
          up_down_nxt = 1'b1;
          rise_nxt    = 1'b1;
        end else begin
          qcnt_nxt = qcnt + QCNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_nxt = QUAL_LO;
          qcnt_nxt  = QCNT_ONE;
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_nxt  = STABLE_HI;
          qcnt_nxt   = '0;
          glitch_hit = 1'b1;
        end else if (qcnt == QCNT_LAST) begin
          state_nxt   = STABLE_LO;
          qcnt_nxt    = '0;
          up_down_nxt = 1'b0;
          fall_nxt    = 1'b1;
        end else begin
          qcnt_nxt = qcnt + QCNT_ONE;
        end
      end
      default: begin
        state_nxt   = STABLE_LO;
        qcnt_nxt    = '0;
        up_down_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt == QUAL_HI) || (state_nxt == QUAL_LO);
  end

  // FSM state, qualification counter and registered direction outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STABLE_LO;
      qcnt       <= '0;
      up_down    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      qcnt       <= qcnt_nxt;
      up_down    <= up_down_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= busy_nxt;
    end
  end

  // Rejected-change counter; a clear on the same edge as a rejection wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_hit) begin
      glitch_cnt <= sat_inc(glitch_cnt);
    end
  end

endmodule
